// File: rtl/queue_cntrl_wm.sv
// Pointer, occupancy and watermark controller for an external N-entry queue array.
// Supports non-power-of-two depth, synchronous flush and sticky overflow/underflow capture.
module queue_cntrl_wm #(
    parameter int unsigned N         = 8,
    parameter int unsigned AF_THRESH = N - 1,
    parameter int unsigned AE_THRESH = 1,
    localparam int unsigned AW       = $clog2(N),
    localparam int unsigned CW       = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic          i_err_clr,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic          o_err_ovf,
    output logic          o_err_udf
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push_ok, pop_ok;

    // Acceptance uses only the registered flags, so a same-cycle pop never frees room for a push.
    assign push_ok = i_push & ~full_q & ~i_flush;
    assign pop_ok  = i_pop & ~empty_q & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == AW'(N - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == AW'(N - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        full_d   = (count_d == CW'(N));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AF_THRESH));
        aempty_d = (count_d <= CW'(AE_THRESH));
    end

    // A new error event takes priority over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (i_push & full_q & ~i_flush) begin
            ovf_d = 1'b1;
        end else if (i_err_clr) begin
            ovf_d = 1'b0;
        end
        if (i_pop & empty_q & ~i_flush) begin
            udf_d = 1'b1;
        end else if (i_err_clr) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign o_wr_en        = push_ok;
    assign o_rd_en        = pop_ok;
    assign o_wr_addr      = wr_ptr_q;
    assign o_rd_addr      = rd_ptr_q;
    assign o_count        = count_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_err_ovf      = ovf_q;
    assign o_err_udf      = udf_q;

endmodule

// File: tb/tb_queue_cntrl_wm.sv
// Bench for queue_cntrl_wm (N=5, AF=4, AE=1): directed vector table, hand sequences,
// and random traffic checked against a queue-based occupancy model.
module tb_queue_cntrl_wm;

    localparam int N  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic       clk;
    logic       arst_n;
    logic       i_push, i_pop, i_flush, i_err_clr;
    logic       o_wr_en, o_rd_en;
    logic [2:0] o_wr_addr, o_rd_addr, o_count;
    logic       o_full, o_empty, o_almost_full, o_almost_empty, o_err_ovf, o_err_udf;

    queue_cntrl_wm #(
        .N         (N),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_push         (i_push),
        .i_pop          (i_pop),
        .i_flush        (i_flush),
        .i_err_clr      (i_err_clr),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_err_ovf      (o_err_ovf),
        .o_err_udf      (o_err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic push, pop, flush, clr;
        logic wr_en, rd_en;
        int   cnt, wa, ra;
        logic full, empty, af, ae, ovf, udf;
    } vec_t;

    vec_t vecs[15];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: occupancy, modular pointers and the addresses written but not yet read.
    int   m_count, m_wr, m_rd;
    logic m_ovf, m_udf;
    int   m_q[$];

    function automatic vec_t mk(input logic [3:0] in, input logic [1:0] st, input int cnt,
                                input int wa, input int ra, input logic [5:0] fl);
        vec_t v;
        {v.push, v.pop, v.flush, v.clr} = in;
        {v.wr_en, v.rd_en} = st;
        v.cnt = cnt;
        v.wa  = wa;
        v.ra  = ra;
        {v.full, v.empty, v.af, v.ae, v.ovf, v.udf} = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wr    = 0;
        m_rd    = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_q.delete();
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".count"}, 32'(o_count), 32'(m_count));
        check({tag, ".wr_addr"}, 32'(o_wr_addr), 32'(m_wr));
        check({tag, ".rd_addr"}, 32'(o_rd_addr), 32'(m_rd));
        check({tag, ".full"}, 32'(o_full), 32'(m_count == N));
        check({tag, ".empty"}, 32'(o_empty), 32'(m_count == 0));
        check({tag, ".afull"}, 32'(o_almost_full), 32'(m_count >= AF));
        check({tag, ".aempty"}, 32'(o_almost_empty), 32'(m_count <= AE));
        check({tag, ".ovf"}, 32'(o_err_ovf), 32'(m_ovf));
        check({tag, ".udf"}, 32'(o_err_udf), 32'(m_udf));
    endtask

    // One cycle: drive at negedge, check strobes before the edge, registered state after it.
    task automatic step(input logic push, input logic pop, input logic flush, input logic clr,
                        input int vi);
        logic exp_wr, exp_rd;
        int   tmp;
        @(negedge clk);
        i_push    = push;
        i_pop     = pop;
        i_flush   = flush;
        i_err_clr = clr;
        #1;
        exp_wr = push && (m_count != N) && !flush;
        exp_rd = pop && (m_count != 0) && !flush;
        check("wr_en", 32'(o_wr_en), 32'(exp_wr));
        check("rd_en", 32'(o_rd_en), 32'(exp_rd));
        if (exp_rd && m_q.size() > 0) check("rd_order", 32'(o_rd_addr), 32'(m_q[0]));
        if (vi >= 0) begin
            check("vec.wr_en", 32'(o_wr_en), 32'(vecs[vi].wr_en));
            check("vec.rd_en", 32'(o_rd_en), 32'(vecs[vi].rd_en));
        end
        if (push && (m_count == N) && !flush) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop && (m_count == 0) && !flush) m_udf = 1'b1;
        else if (clr) m_udf = 1'b0;
        if (flush) begin
            m_count = 0;
            m_wr    = 0;
            m_rd    = 0;
            m_q.delete();
        end else begin
            if (exp_wr) begin
                m_q.push_back(m_wr);
                m_wr = (m_wr + 1) % N;
                m_count++;
            end
            if (exp_rd) begin
                tmp  = m_q.pop_front();
                m_rd = (m_rd + 1) % N;
                m_count--;
            end
        end
        @(posedge clk);
        #1;
        check_regs("model");
        if (vi >= 0) begin
            check("vec.count", 32'(o_count), 32'(vecs[vi].cnt));
            check("vec.wr_addr", 32'(o_wr_addr), 32'(vecs[vi].wa));
            check("vec.rd_addr", 32'(o_rd_addr), 32'(vecs[vi].ra));
            check("vec.full", 32'(o_full), 32'(vecs[vi].full));
            check("vec.empty", 32'(o_empty), 32'(vecs[vi].empty));
            check("vec.afull", 32'(o_almost_full), 32'(vecs[vi].af));
            check("vec.aempty", 32'(o_almost_empty), 32'(vecs[vi].ae));
            check("vec.ovf", 32'(o_err_ovf), 32'(vecs[vi].ovf));
            check("vec.udf", 32'(o_err_udf), 32'(vecs[vi].udf));
        end
    endtask

    initial begin
        // inputs {push,pop,flush,clr} | strobes {wr,rd} | count, wr_addr, rd_addr |
        // flags {full,empty,afull,aempty,ovf,udf}
        vecs[0]  = mk(4'b1000, 2'b10, 1, 1, 0, 6'b000100);
        vecs[1]  = mk(4'b1000, 2'b10, 2, 2, 0, 6'b000000);
        vecs[2]  = mk(4'b1000, 2'b10, 3, 3, 0, 6'b000000);
        vecs[3]  = mk(4'b1000, 2'b10, 4, 4, 0, 6'b001000);
        vecs[4]  = mk(4'b1000, 2'b10, 5, 0, 0, 6'b101000);
        vecs[5]  = mk(4'b1100, 2'b01, 4, 0, 1, 6'b001010);
        vecs[6]  = mk(4'b0001, 2'b00, 4, 0, 1, 6'b001000);
        vecs[7]  = mk(4'b0100, 2'b01, 3, 0, 2, 6'b000000);
        vecs[8]  = mk(4'b0100, 2'b01, 2, 0, 3, 6'b000000);
        vecs[9]  = mk(4'b0100, 2'b01, 1, 0, 4, 6'b000100);
        vecs[10] = mk(4'b0100, 2'b01, 0, 0, 0, 6'b010100);
        vecs[11] = mk(4'b1101, 2'b10, 1, 1, 0, 6'b000101);
        vecs[12] = mk(4'b1000, 2'b10, 2, 2, 0, 6'b000001);
        vecs[13] = mk(4'b1000, 2'b10, 3, 3, 0, 6'b000001);
        vecs[14] = mk(4'b1010, 2'b00, 0, 0, 0, 6'b010101);

        arst_n    = 1'b0;
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_flush   = 1'b0;
        i_err_clr = 1'b0;
        model_reset();
        #12;
        check("reset.wr_en", 32'(o_wr_en), 32'd0);
        check("reset.rd_en", 32'(o_rd_en), 32'd0);
        check_regs("reset");
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, i);
        end

        // Wrap-around: steady pushes with interleaved pops, checking read order via the model.
        step(1'b0, 1'b0, 1'b0, 1'b1, -1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i % 3) != 0, 1'b0, 1'b0, -1);
            check("wrap.count_le_n", 32'(o_count <= 3'(N)), 32'd1);
        end

        // Random traffic in push-heavy, pop-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int pp;
                pp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
                step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
                     $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6, -1);
            end
        end

        // Asynchronous reset mid-cycle at count 3 with a sticky error pending.
        step(1'b0, 1'b0, 1'b1, 1'b0, -1);
        step(1'b0, 1'b1, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("pre_reset.count", 32'(o_count), 32'd3);
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_flush   = 1'b0;
        i_err_clr = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.wr_en", 32'(o_wr_en), 32'd0);
        check_regs("midrst");
        @(negedge clk);
        arst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("resume.wr_addr", 32'(o_wr_addr), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
